// File: rtl/data_stream_fifo.sv
// Register-based valid/ready FIFO that buffers a stream without upstream back-pressure.
// It reports occupancy and sets a sticky overflow flag when a word arrives while full.
module data_stream_fifo #(
  parameter int DATA_BW = 10,
  parameter int DEPTH   = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_clear,
  input  logic                     i_valid,
  input  logic [DATA_BW-1:0]       i_data,
  output logic                     o_ready,
  output logic                     o_valid,
  output logic [DATA_BW-1:0]       o_data,
  input  logic                     i_ready,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_overflow
);

  localparam int PTR_BW = $clog2(DEPTH);
  localparam int CNT_BW = PTR_BW + 1;
  localparam logic [CNT_BW-1:0] FULL_CNT = CNT_BW'(DEPTH);

  logic [DATA_BW-1:0] mem_q [DEPTH];
  logic [PTR_BW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_BW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_BW-1:0]  cnt_q, cnt_d;
  logic               ovf_q, ovf_d;
  logic               push, pop;

  // Handshake outputs come from registered state only; no input-to-output path.
  assign o_ready    = (cnt_q != FULL_CNT);
  assign o_valid    = (cnt_q != '0);
  assign o_data     = mem_q[rd_ptr_q];
  assign o_count    = cnt_q;
  assign o_overflow = ovf_q;

  assign push = i_valid & o_ready;
  assign pop  = o_valid & i_ready;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    ovf_d    = ovf_q;
    if (i_clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
      ovf_d    = 1'b0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_BW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_BW'(1);
      case ({push, pop})
        2'b10:   cnt_d = cnt_q + CNT_BW'(1);
        2'b01:   cnt_d = cnt_q - CNT_BW'(1);
        default: cnt_d = cnt_q;
      endcase
      // A word offered while full is dropped; remember it until reset or clear.
      if (i_valid & ~o_ready) ovf_d = 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (push && !i_clear) begin
      mem_q[wr_ptr_q] <= i_data;
    end
  end

endmodule

// File: doc/data_stream_fifo.md
# data_stream_fifo

Synchronous valid/ready FIFO that buffers a fixed-latency pixel/feature stream, such as the output of a pipeline delay line, for a downstream consumer that can stall. It takes a stream with no back-pressure from the upstream delay stage. It exposes a standard valid/ready handshake downstream and reports occupancy so the upstream controller can throttle before overflow. It has one clock domain, no gray coding, and register-based storage.

## Interface
- DATA_BW, default 10: payload width in bits.
- DEPTH, default 4: number of entries.
  - Must be a power of two and ≥ 2.
  - Pointer width PTR_BW = $clog2(DEPTH).
  - Count width CNT_BW = PTR_BW+1.
- i_clk, input, 1: clock. All logic is on the rising edge.
- i_rst_n, input, 1: reset, asynchronous and active-low.
- i_clear, input, 1: synchronous flush. It empties the FIFO on the next edge.
- i_valid, input, 1: upstream word present on i_data.
- i_data, input, DATA_BW: upstream payload.
- o_ready, output, 1: FIFO can accept a word this cycle.
- o_valid, output, 1: o_data holds the head word.
- o_data, output, DATA_BW: head-of-FIFO payload.
- i_ready, input, 1: downstream accepts the head word this cycle.
- o_count, output, CNT_BW: current occupancy, 0..DEPTH.
- o_overflow, output, 1: sticky flag. It is set when i_valid=1 while o_ready=0, meaning the upstream dropped a word.

## Operation
- Storage:
  - DEPTH×DATA_BW register array.
  - Write pointer wr_ptr and read pointer rd_ptr, each PTR_BW bits, wrapping modulo DEPTH.
  - Occupancy counter cnt, CNT_BW bits.
- Push:
  - push = i_valid & o_ready.
  - On push, mem[wr_ptr] ← i_data and wr_ptr ← wr_ptr+1.
- Pop:
  - pop = o_valid & i_ready.
  - On pop, rd_ptr ← rd_ptr+1.
- Counter update:
  - cnt ← cnt+1 on push only.
  - cnt ← cnt−1 on pop only.
  - cnt unchanged when both or neither occur.
- Derived signals:
  - o_ready = (cnt != DEPTH). It depends on registered state only and never on i_ready.
  - o_valid = (cnt != 0).
  - o_data = mem[rd_ptr].
  - o_count = cnt.
- Full with simultaneous pop: o_ready=0, so no push that cycle even though a pop frees an entry. The next cycle o_ready=1.
- Empty with i_valid=1: no pop is possible that cycle. There is no fall-through; the word appears at the output the next cycle.
- Simultaneous push and pop at partial occupancy: both complete and cnt is unchanged. Pointer wrap from DEPTH−1 to 0 is seamless.
- Overflow:
  - o_overflow ← 1 in any cycle with i_valid & ~o_ready.
  - The offending word is discarded and the FIFO contents are unaffected.
  - The flag is cleared only by reset or i_clear.
- Clear:
  - i_clear=1 sets wr_ptr, rd_ptr and cnt to 0 and o_overflow to 0 on the next edge.
  - It overrides any push or pop in the same cycle.
  - Memory contents are not cleared.
- Reset, asynchronous:
  - wr_ptr=0, rd_ptr=0, cnt=0 and every mem entry = 0.
  - Therefore o_valid=0, o_ready=1, o_data=0, o_count=0 and o_overflow=0.
  - Reset asserted mid-stream discards all contents immediately, without waiting for a clock edge.
- o_data while o_valid=0 is the stale mem[rd_ptr]. It is defined but carries no meaning, and the bench must not check it.

## Timing
- Write-to-read latency is 1 cycle. A word pushed at edge N is visible on o_valid/o_data after edge N, so it can be popped in cycle N+1 at the earliest.
- o_ready, o_valid and o_count are all functions of registered state only. There is no combinational path from i_valid or i_ready to any output.
- Sustained throughput is 1 word/cycle while 0 < cnt < DEPTH with push and pop every cycle.
- o_count changes only on the clock edge following a push or pop imbalance, or on clear or reset.

## Test plan
- Reset and basic fill/drain:
  - Stimulus: after reset, push 0x001..0x004 on consecutive cycles with i_ready=0.
  - Response: o_count steps 1,2,3,4; o_ready=0 at count 4. Then with i_ready=1, o_data reads 0x001..0x004 on consecutive cycles, and o_valid=0 after the 4th pop.
- Streaming and wrap:
  - Stimulus: i_valid=i_ready=1 continuously for 20 cycles with an incrementing payload.
  - Response: output equals input delayed by 1 cycle, o_count stays 1, and the pointers wrap five times with no loss.
- Full with simultaneous pop:
  - Stimulus: at count 4, drive i_valid=1 and i_ready=1.
  - Response: the head is popped, the incoming word is not accepted, o_overflow=1, and o_count=3 next cycle. The dropped value never appears at the output.
- Random back-pressure:
  - Stimulus: 1000 random i_valid/i_ready cycles, with upstream honouring o_ready.
  - Response: output order matches a reference queue exactly, o_count matches the model every cycle, and o_overflow stays 0.
- Clear with push and pop:
  - Stimulus: at count 3, assert i_clear with i_valid=1 and i_ready=1.
  - Response: next cycle o_count=0, o_valid=0, o_ready=1 and o_overflow=0.
- Asynchronous reset mid-operation:
  - Stimulus: at count 2, drop i_rst_n between clock edges.
  - Response: immediately o_valid=0, o_count=0 and o_data=0. After release, the first push of 0x3FF appears at the output 1 cycle later.
